// File: rtl/walk_sfx_voice_bank.sv
// walk_sfx_voice_bank
// -------------------
// A bank of NUM_VOICES independent "walk" sound effects. Each voice has three parts:
//   - a slew-limited trigger level;
//   - a diode-clamped high-pass envelope;
//   - an LFO-modulated square VCO that gates the envelope.
// One shared datapath is time-multiplexed across the voices, one voice per clk,
// after each sample strobe. The voice outputs are then summed into one signed sample.
//
// Ports
//   clk          in   system clock
//   I_RST        in   synchronous active-high reset
//   audio_clk_en in   one-clk sample strobe; starts a sweep when idle
//   trigger      in   [NUM_VOICES] per-voice effect enable (level)
//   out          out  [WIDTH] signed mixed sample, registered
//   busy         out  high while a sweep (PROC or MIX) is in progress
//   overrun      out  sticky: a strobe arrived while busy
//
// Optional build macro: WALK_SFX_MIX_SAT_EN
//   defined   -> out is the full voice sum, saturated to the WIDTH-bit signed range
//   undefined -> out is the voice sum arithmetically shifted down by $clog2(NUM_VOICES)
`timescale 1ns/1ps

module walk_sfx_voice_bank #(
  parameter int NUM_VOICES      = 2,
  parameter int WIDTH           = 16,
  parameter int V_ON            = 6826,
  parameter int SLEW_STEP       = 27,
  parameter int DECAY_SHIFT     = 6,
  parameter int LFO_HALF_PERIOD = 2400,
  parameter int BASE_INC        = 1092,
  parameter int MOD_INC         = 546
) (
  input  logic                    clk,
  input  logic                    I_RST,
  input  logic                    audio_clk_en,
  input  logic [NUM_VOICES-1:0]   trigger,
  output logic signed [WIDTH-1:0] out,
  output logic                    busy,
  output logic                    overrun
);

  localparam int AW        = WIDTH + 2;
  localparam int MIX_SHIFT = $clog2(NUM_VOICES);
  localparam int SUMW      = WIDTH + MIX_SHIFT + 1;
  localparam int IDXW      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int LFOW      = (LFO_HALF_PERIOD > 1) ? $clog2(LFO_HALF_PERIOD) : 1;

  localparam logic signed [AW-1:0] VON_A      = AW'(V_ON);
  localparam logic signed [AW-1:0] SLEW_A     = AW'(SLEW_STEP);
  localparam logic [LFOW-1:0]      LFO_LAST   = LFOW'(LFO_HALF_PERIOD - 1);
  localparam logic [IDXW-1:0]      IDX_LAST   = IDXW'(NUM_VOICES - 1);
  localparam logic [15:0]          BASE_INC16 = 16'(BASE_INC);
  localparam logic [15:0]          MOD_INC16  = 16'(MOD_INC);

  typedef enum logic [1:0] {IDLE, PROC, MIX} state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            procEn, mixEn;

  logic signed [WIDTH-1:0] level_q    [NUM_VOICES];
  logic signed [WIDTH-1:0] baseline_q [NUM_VOICES];
  logic signed [WIDTH-1:0] voiceOut_q [NUM_VOICES];
  logic [LFOW-1:0]         lfoCnt_q   [NUM_VOICES];
  logic [15:0]             phase_q    [NUM_VOICES];
  logic [NUM_VOICES-1:0]   lfo_q;
  logic signed [WIDTH-1:0] out_q;
  logic                    overrun_q;

  logic                    curTrig, lfoOld, lfoNew;
  logic signed [AW-1:0]    levelOld, baseOld, target, diff, levelNew, envRaw, env, baseNew;
  logic [LFOW-1:0]         lfoCntNew;
  logic [15:0]             phaseNew;
  logic signed [WIDTH-1:0] voiceNew;
  logic signed [SUMW-1:0]  mixSum;
  logic signed [WIDTH-1:0] mixOut;

  // Sweep sequencer state and the index of the voice being processed.
  always_ff @(posedge clk) begin
    if (I_RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // A strobe only starts a sweep from IDLE; strobes during PROC/MIX are dropped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (audio_clk_en) begin
          state_d = PROC;
          idx_d   = '0;
        end
      end
      PROC: begin
        if (idx_q == IDX_LAST) state_d = MIX;
        else                   idx_d   = idx_q + IDXW'(1);
      end
      MIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decoded controls for the datapath.
  always_comb begin
    busy   = (state_q != IDLE);
    procEn = (state_q == PROC);
    mixEn  = (state_q == MIX);
  end

  // Shared per-voice datapath. Every term below is built only from the selected
  // voice's old state, so the whole voice is updated in a single clk.
  always_comb begin
    curTrig  = trigger[idx_q];
    levelOld = AW'(level_q[idx_q]);
    baseOld  = AW'(baseline_q[idx_q]);
    target   = curTrig ? VON_A : '0;
    diff     = target - levelOld;
    if (diff > SLEW_A)       levelNew = levelOld + SLEW_A;
    else if (diff < -SLEW_A) levelNew = levelOld - SLEW_A;
    else                     levelNew = target;

    // The same difference drives both the clamped envelope and the baseline tracking.
    envRaw  = levelNew - baseOld;
    env     = envRaw[AW-1] ? '0 : envRaw;
    baseNew = baseOld + (envRaw >>> DECAY_SHIFT);

    // The phase increment uses the LFO value from before this update.
    lfoOld = lfo_q[idx_q];
    if (!curTrig) begin
      lfoCntNew = '0;
      lfoNew    = 1'b0;
    end else if (lfoCnt_q[idx_q] == LFO_LAST) begin
      lfoCntNew = '0;
      lfoNew    = ~lfoOld;
    end else begin
      lfoCntNew = lfoCnt_q[idx_q] + LFOW'(1);
      lfoNew    = lfoOld;
    end
    phaseNew = phase_q[idx_q] + BASE_INC16 + (lfoOld ? MOD_INC16 : 16'd0);
    voiceNew = phaseNew[15] ? WIDTH'(env) : '0;
  end

  // The mix is formed from the registered voice outputs while in MIX.
  always_comb begin
    mixSum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mixSum = mixSum + SUMW'(voiceOut_q[i]);
    end
`ifdef WALK_SFX_MIX_SAT_EN
    if (mixSum > SUMW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1))
      mixOut = {1'b0, {(WIDTH-1){1'b1}}};
    else if (mixSum < -SUMW'(64'sd1 <<< (WIDTH - 1)))
      mixOut = {1'b1, {(WIDTH-1){1'b0}}};
    else
      mixOut = WIDTH'(mixSum);
`else
    mixOut = WIDTH'(mixSum >>> MIX_SHIFT);
`endif
  end

  // Per-voice state, mixed output and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (I_RST) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        level_q[i]    <= '0;
        baseline_q[i] <= '0;
        voiceOut_q[i] <= '0;
        lfoCnt_q[i]   <= '0;
        phase_q[i]    <= '0;
      end
      lfo_q     <= '0;
      out_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (procEn) begin
        level_q[idx_q]    <= WIDTH'(levelNew);
        baseline_q[idx_q] <= WIDTH'(baseNew);
        voiceOut_q[idx_q] <= voiceNew;
        lfoCnt_q[idx_q]   <= lfoCntNew;
        lfo_q[idx_q]      <= lfoNew;
        phase_q[idx_q]    <= phaseNew;
      end
      if (mixEn) out_q <= mixOut;
      if (busy && audio_clk_en) overrun_q <= 1'b1;
    end
  end

  assign out     = out_q;
  assign overrun = overrun_q;

endmodule
